// File: rtl/lsu_pkg.sv
// Shared load/store definitions: FSM states, RV32I width codes
// and the access legality check also used by the core decoder.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 1 when the access is illegal for its direction or misaligned.
  function automatic logic lsu_bad_access(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = lo[0];
      F3_HU:   bad = we | lo[0];
      F3_W:    bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_format.sv
// Lane select/extend for loads and lane merge for sub-word stores.
// Purely combinational.
module lsu_format
  import lsu_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [4:0]  lane;
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  assign lane    = {lo_i, 3'b000};
  assign shifted = rword_i >> lane;
  assign b       = shifted[7:0];
  assign h       = lo_i[1] ? rword_i[31:16]
                           : rword_i[15:0];

  always_comb begin
    load_o = rword_i;
    case (funct3_i)
      F3_B:    load_o = {{24{b[7]}}, b};
      F3_BU:   load_o = {24'h0, b};
      F3_H:    load_o = {{16{h[15]}}, h};
      F3_HU:   load_o = {16'h0, h};
      default: load_o = rword_i;
    endcase
  end

  always_comb begin
    store_o = rword_i;
    case (funct3_i)
      F3_B: store_o[lane +: 8] = wdata_i[7:0];
      F3_H: begin
        if (lo_i[1]) store_o[31:16] = wdata_i[15:0];
        else         store_o[15:0]  = wdata_i[15:0];
      end
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle RV32I load/store unit for a word-wide RAM without
// byte enables; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_ADDR_W = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  output logic                   mem_we,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata
);

  lsu_state_e state_q, state_d;

  logic                   we_q, we_d;
  logic [2:0]             f3_q, f3_d;
  logic [1:0]             lo_q, lo_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [WORD_ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]            mwdata_q, mwdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [31:0] fmt_load;
  logic [31:0] fmt_store;

  // High address bits wrap the access modulo RAM size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:WORD_ADDR_W+2];

  lsu_format u_format (
    .rword_i  (mem_rdata),
    .wdata_i  (wdata_q),
    .lo_i     (lo_q),
    .funct3_i (f3_q),
    .load_o   (fmt_load),
    .store_o  (fmt_store)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    lo_d     = lo_q;
    wdata_d  = wdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          lo_d    = req_addr[1:0];
          wdata_d = req_wdata;
          maddr_d = req_addr[WORD_ADDR_W+1:2];
          if (lsu_bad_access(req_we, req_funct3,
                             req_addr[1:0])) begin
            state_d = S_RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else if (req_we && req_funct3 == F3_W) begin
            state_d  = S_WRITE;
            mwdata_d = req_wdata;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (we_q) begin
          mwdata_d = fmt_store;
          state_d  = S_WRITE;
        end else begin
          rdata_d = fmt_load;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      lo_q     <= 2'b00;
      wdata_q  <= 32'h0;
      maddr_q  <= '0;
      mwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      lo_q     <= lo_d;
      wdata_q  <= wdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle load/store unit between the RV32I core FSM and the word-wide data RAM. It accepts one load or store request per handshake and decodes byte/halfword/word width from funct3. Sub-word stores are done as read-modify-write, because the RAM port has no byte enables. Loads return the addressed data zero- or sign-extended, and misaligned or illegal accesses return an error without touching memory.

## Interface
- WORD_ADDR_W, 11, RAM word-address width (2^11 words = 8 KiB)
- clk  in  1  core clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept; high exactly when in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte or half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  formatted load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; misaligned or illegal funct3
- mem_addr  out  WORD_ADDR_W  RAM word address, equal to req_addr[WORD_ADDR_W+1:2]
- mem_we  out  1  RAM write strobe
- mem_wdata  out  32  RAM write word
- mem_rdata  in  32  RAM read word, valid one cycle after mem_addr is presented

## Operation
- States: IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata.
  - If illegal or misaligned, go to RESP with err=1.
  - Otherwise, SW goes to WRITE; every other access goes to READ.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other code is illegal, giving err=1.
- Misaligned:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠00.
- Address bits above WORD_ADDR_W+1 are ignored, so accesses wrap modulo RAM size.
- READ: mem_addr holds the latched word address. Go to CAPTURE.
- CAPTURE: mem_rdata is valid in this state.
  - Load: select the byte or half by addr[1:0], extend it (sign for 000/001, zero for 100/101), register it into resp_rdata, go to RESP.
  - SB/SH: merge the low bits of wdata into the read word at the addressed lane, register the result into mem_wdata, go to WRITE.
- WRITE: mem_we=1 for exactly this cycle. For SW, mem_wdata = wdata. Go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. resp_rdata and resp_err hold their values until the next RESP.
- mem_we is a decode of state==WRITE. It is never high in any other state.

## Timing
- Accept cycle = cycle 0 (IDLE with req_valid). resp_valid rises in:
  - Error: cycle 1.
  - SW: cycle 2 (write at cycle 1).
  - Load: cycle 3.
  - SB/SH: cycle 4 (write at cycle 3).
- A back-to-back request is accepted in the cycle after RESP at the earliest. req_valid during a busy state is ignored; the core holds the request.
- Reset values:
  - State IDLE, so req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_addr=0, mem_wdata=0, mem_we=0.
- Reset mid-operation: the operation is abandoned and no response is issued. If reset coincides with WRITE, that single write still lands at the same edge. Reset in READ/CAPTURE produces no write.
- Read data from CAPTURE is used directly. The RAM is not re-read and there is no forwarding, since only one request is ever in flight.

## Structure
- lsu_pkg holds:
  - the state enum;
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - a legality/alignment check function shared with the core decoder.
- Sub-module lsu_format, purely combinational:
  - load extract/extend (word, addr[1:0], funct3 → 32-bit value);
  - store merge (old word, wdata, addr[1:0], funct3 → new word).
- The FSM and registers stay in load_store_unit.

## Test plan
- RAM[0x4>>2]=0x8899AABB; LB addr 0x5 → resp_rdata 0xFFFFFFAA, err=0, resp at cycle 3. LBU addr 0x5 → 0x000000AA. LHU addr 0x6 → 0x00008899.
- SB addr 0x6 data 0x12345677 over 0x8899AABB → single mem_we pulse at cycle 3 with wdata 0x8877AABB; a following LW addr 0x4 returns 0x8877AABB.
- SW addr 0x10 data 0xDEADBEEF → mem_we at cycle 1 with mem_addr 4; resp at cycle 2 with rdata 0.
- LW addr 0x2, SH addr 0x3, and load funct3=011 → err=1 at cycle 1; mem_we never asserted; RAM unchanged.
- Reset asserted in CAPTURE of an SH → no mem_we, no resp_valid; all outputs at reset values; req_ready=1 the next cycle.
- req_valid held high continuously with alternating LW/SW → each accepted only in IDLE, one response per request, no request dropped or duplicated.
